// File: rtl/batch_pkg.sv
// Shared types, default geometry and address helper for the batch scheduler.
package batch_pkg;

    localparam int DEF_DEPTH    = 32;
    localparam int DEF_SEGMENTS = 4;

    localparam int DS_ADDR_W  = $clog2(DEF_DEPTH * DEF_SEGMENTS);
    localparam int RES_ADDR_W = $clog2(2 * DEF_DEPTH);

    typedef logic [$clog2(DEF_DEPTH)-1:0]    idx_t;
    typedef logic [$clog2(DEF_SEGMENTS)-1:0] seg_t;
    typedef logic                            bank_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // Sample-ring layout interleaves segments: consecutive segments of one index are adjacent.
    function automatic int unsigned addr_of(input int unsigned idx, input int unsigned seg,
                                            input int unsigned segments = DEF_SEGMENTS);
        return idx * segments + seg;
    endfunction

endpackage

// File: rtl/batch_delay_line.sv
// Tapped shift register advancing one stage per enable; taps_o[k] holds the input from k+1 enables ago.
module batch_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic [WIDTH-1:0]            din_i,
    output logic [DEPTH-1:0][WIDTH-1:0] taps_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the old value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= (DEPTH * WIDTH)'({stage_q, din_i});
        end
    end

    assign taps_o = stage_q;

endmodule

// File: rtl/batch_scheduler.sv
// Batch scheduler: packs OSR samples per downsampled tick and sequences ring/result addresses.
// Define BATCH_IN_VALID_EN to add the in_valid sample qualifier port.
module batch_scheduler
    import batch_pkg::*;
#(
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int N        = 3,
    parameter  int OSR      = 1,
    parameter  int SEGMENTS = DEF_SEGMENTS,
    parameter  int RES_LAT  = 3,
    localparam int DS_AW    = $clog2(DEPTH * SEGMENTS),
    localparam int RES_AW   = $clog2(2 * DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BATCH_IN_VALID_EN
    input  logic              in_valid,
`endif
    input  logic [N-1:0]      in,
    output logic              ds_tick,
    output logic              samp_we,
    output logic [N*OSR-1:0]  samp_wdata,
    output logic [DS_AW-1:0]  samp_waddr,
    output logic [DS_AW-1:0]  samp_lh,
    output logic [DS_AW-1:0]  samp_fr,
    output logic [DS_AW-1:0]  samp_br,
    output logic              res_we,
    output logic [RES_AW-1:0] res_waddr,
    output logic [RES_AW-1:0] res_raddr_f,
    output logic [RES_AW-1:0] res_raddr_b,
    output logic              rec_clr,
    output logic              out_valid
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SEG_W = $clog2(SEGMENTS);
    localparam int BC_W  = $clog2(SEGMENTS + 1);
    localparam int PC_W  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int PK_W  = N * OSR;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGMENTS - 1);
    localparam logic [DS_AW-1:0] LH_RST   = DS_AW'(addr_of(DEPTH - 1, SEGMENTS - 1, SEGMENTS));
    localparam logic [DS_AW-1:0] BR_RST   = DS_AW'(addr_of(DEPTH - 1, 1, SEGMENTS));

    logic                        accept;
    logic                        tick;
    logic [PC_W-1:0]             pcnt_q, pcnt_d;
    logic [PK_W-1:0]             pack_q, pack_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SEG_W-1:0]            w_q, w_d;
    bank_t                       bank_q, bank_d;
    logic [BC_W-1:0]             bcnt_q, bcnt_d;
    sched_state_e                state_q, state_d;
    logic                        run;

    logic [SEG_W-1:0]            lh_seg, calc_seg;
    logic [IDX_W-1:0]            rev_idx;
    logic [RES_LAT-1:0][IDX_W-1:0] idx_taps;
    logic [RES_LAT-1:0]          bank_taps, run_taps, vld_taps;
    logic [IDX_W-1:0]            idx_wr, idx_rd;
    bank_t                       bank_wr, bank_rd;

    logic                        ds_tick_q, ds_tick_d;
    logic [PK_W-1:0]             wdata_q, wdata_d;
    logic [DS_AW-1:0]            waddr_q, waddr_d, lh_q, lh_d, fr_q, fr_d, br_q, br_d;
    logic                        res_we_q, res_we_d;
    logic [RES_AW-1:0]           rwaddr_q, rwaddr_d, rf_q, rf_d, rb_q, rb_d;
    logic                        rec_clr_q, rec_clr_d;
    logic                        out_valid_q, out_valid_d;

`ifdef BATCH_IN_VALID_EN
    assign accept = in_valid;
`else
    assign accept = 1'b1;
`endif

    assign tick = accept && (pcnt_q == PC_W'(OSR - 1));

    // Result-path delay lines: tap RES_LAT-1 feeds the write side, tap RES_LAT-2 the read side.
    batch_delay_line #(.WIDTH(IDX_W), .DEPTH(RES_LAT)) u_idx_d (
        .clk(clk), .rst(rst), .en_i(tick), .din_i(idx_q), .taps_o(idx_taps)
    );
    batch_delay_line #(.WIDTH(1), .DEPTH(RES_LAT)) u_bank_d (
        .clk(clk), .rst(rst), .en_i(tick), .din_i(bank_q), .taps_o(bank_taps)
    );
    batch_delay_line #(.WIDTH(1), .DEPTH(RES_LAT)) u_run_d (
        .clk(clk), .rst(rst), .en_i(tick), .din_i(run), .taps_o(run_taps)
    );
    batch_delay_line #(.WIDTH(1), .DEPTH(RES_LAT)) u_vld_d (
        .clk(clk), .rst(rst), .en_i(tick), .din_i(1'b1), .taps_o(vld_taps)
    );

    assign idx_wr  = idx_taps[RES_LAT-1];
    assign bank_wr = bank_taps[RES_LAT-1];
    assign idx_rd  = idx_taps[RES_LAT-2];
    assign bank_rd = bank_taps[RES_LAT-2];

    // calc = w-(SEGMENTS-1) mod SEGMENTS, which is simply the segment after the write segment.
    always_comb begin
        lh_seg   = SEG_W'((32'(w_q) + 32'(SEGMENTS) - 32'd1) % 32'(SEGMENTS));
        calc_seg = SEG_W'((32'(w_q) + 32'd1) % 32'(SEGMENTS));
        rev_idx  = IDX_LAST - idx_q;
    end

    // NOTE: every combinational output gets a hold/default value first so no latch is inferred.
    always_comb begin
        pcnt_d   = pcnt_q;
        pack_d   = pack_q;
        idx_d    = idx_q;
        w_d      = w_q;
        bank_d   = bank_q;
        bcnt_d   = bcnt_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        lh_d     = lh_q;
        fr_d     = fr_q;
        br_d     = br_q;
        rwaddr_d = rwaddr_q;
        rf_d     = rf_q;
        rb_d     = rb_q;

        if (accept) begin
            pack_d = PK_W'({pack_q, in});
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        if (tick) begin
            wdata_d  = pack_d;
            waddr_d  = DS_AW'(addr_of(32'(idx_q), 32'(w_q), SEGMENTS));
            lh_d     = DS_AW'(addr_of(32'(rev_idx), 32'(lh_seg), SEGMENTS));
            fr_d     = DS_AW'(addr_of(32'(idx_q), 32'(calc_seg), SEGMENTS));
            br_d     = DS_AW'(addr_of(32'(rev_idx), 32'(calc_seg), SEGMENTS));
            rwaddr_d = {idx_wr, bank_wr};
            rf_d     = {idx_rd, ~bank_rd};
            rb_d     = {IDX_LAST - idx_rd, ~bank_rd};
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                w_d    = (w_q == SEG_LAST) ? '0 : w_q + 1'b1;
                bank_d = ~bank_q;
                if (bcnt_q != BC_W'(SEGMENTS)) bcnt_d = bcnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        ds_tick_d   = tick;
        rec_clr_d   = tick && (idx_q == '0);
        res_we_d    = tick && vld_taps[RES_LAT-1];
        out_valid_d = tick && run_taps[RES_LAT-1];
    end

    // FSM: leave FILL on the same tick that the batch count reaches SEGMENTS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FILL;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (tick && (idx_q == IDX_LAST) && (bcnt_q >= BC_W'(SEGMENTS - 1))) state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    always_comb run = (state_q == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q      <= '0;
            pack_q      <= '0;
            idx_q       <= '0;
            w_q         <= '0;
            bank_q      <= 1'b0;
            bcnt_q      <= '0;
            ds_tick_q   <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            lh_q        <= LH_RST;
            fr_q        <= '0;
            br_q        <= BR_RST;
            res_we_q    <= 1'b0;
            rwaddr_q    <= '0;
            rf_q        <= '0;
            rb_q        <= '0;
            rec_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            pack_q      <= pack_d;
            idx_q       <= idx_d;
            w_q         <= w_d;
            bank_q      <= bank_d;
            bcnt_q      <= bcnt_d;
            ds_tick_q   <= ds_tick_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            lh_q        <= lh_d;
            fr_q        <= fr_d;
            br_q        <= br_d;
            res_we_q    <= res_we_d;
            rwaddr_q    <= rwaddr_d;
            rf_q        <= rf_d;
            rb_q        <= rb_d;
            rec_clr_q   <= rec_clr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ds_tick     = ds_tick_q;
    assign samp_we     = ds_tick_q;
    assign samp_wdata  = wdata_q;
    assign samp_waddr  = waddr_q;
    assign samp_lh     = lh_q;
    assign samp_fr     = fr_q;
    assign samp_br     = br_q;
    assign res_we      = res_we_q;
    assign res_waddr   = rwaddr_q;
    assign res_raddr_f = rf_q;
    assign res_raddr_b = rb_q;
    assign rec_clr     = rec_clr_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_batch_scheduler.sv
// Directed bench for batch_scheduler: default, OSR=4/N=2 and SEGMENTS=5/DEPTH=8 instances side by side.
module tb_batch_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] in_a = 3'b101;
    logic [2:0] in_c = 3'b110;
    logic [1:0] in_b = 2'd0;
`ifdef BATCH_IN_VALID_EN
    logic iv_a   = 1'b1;
    logic iv_one = 1'b1;
`endif

    logic       a_tick, a_we, a_rwe, a_rec, a_ov;
    logic [2:0] a_wdata;
    logic [6:0] a_waddr, a_lh, a_fr, a_br;
    logic [5:0] a_rw, a_rf, a_rb;

    logic       b_tick, b_we, b_rwe, b_rec, b_ov;
    logic [7:0] b_wdata;
    logic [6:0] b_waddr, b_lh, b_fr, b_br;
    logic [5:0] b_rw, b_rf, b_rb;

    logic       c_tick, c_we, c_rwe, c_rec, c_ov;
    logic [2:0] c_wdata;
    logic [5:0] c_waddr, c_lh, c_fr, c_br;
    logic [3:0] c_rw, c_rf, c_rb;

    int n_checks = 0;
    int n_pass   = 0;

    batch_scheduler dut_a (
        .clk(clk), .rst(rst),
`ifdef BATCH_IN_VALID_EN
        .in_valid(iv_a),
`endif
        .in(in_a), .ds_tick(a_tick), .samp_we(a_we), .samp_wdata(a_wdata),
        .samp_waddr(a_waddr), .samp_lh(a_lh), .samp_fr(a_fr), .samp_br(a_br),
        .res_we(a_rwe), .res_waddr(a_rw), .res_raddr_f(a_rf), .res_raddr_b(a_rb),
        .rec_clr(a_rec), .out_valid(a_ov)
    );

    batch_scheduler #(.N(2), .OSR(4)) dut_b (
        .clk(clk), .rst(rst),
`ifdef BATCH_IN_VALID_EN
        .in_valid(iv_one),
`endif
        .in(in_b), .ds_tick(b_tick), .samp_we(b_we), .samp_wdata(b_wdata),
        .samp_waddr(b_waddr), .samp_lh(b_lh), .samp_fr(b_fr), .samp_br(b_br),
        .res_we(b_rwe), .res_waddr(b_rw), .res_raddr_f(b_rf), .res_raddr_b(b_rb),
        .rec_clr(b_rec), .out_valid(b_ov)
    );

    batch_scheduler #(.DEPTH(8), .SEGMENTS(5)) dut_c (
        .clk(clk), .rst(rst),
`ifdef BATCH_IN_VALID_EN
        .in_valid(iv_one),
`endif
        .in(in_c), .ds_tick(c_tick), .samp_we(c_we), .samp_wdata(c_wdata),
        .samp_waddr(c_waddr), .samp_lh(c_lh), .samp_fr(c_fr), .samp_br(c_br),
        .res_we(c_rwe), .res_waddr(c_rw), .res_raddr_f(c_rf), .res_raddr_b(c_rb),
        .rec_clr(c_rec), .out_valid(c_ov)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected outputs for tick t of a DEPTH=d, SEGMENTS=s instance with result latency 3.
    task automatic check_tick(input string p, input int t, input int d, input int s,
                              input logic [31:0] we, rec, rwe, ov, waddr, lh, fr, br,
                              input logic [31:0] rw, rf, rb);
        int idx, w, i2, b2, i3, b3;
        string pt;
        idx = t % d;
        w   = (t / d) % s;
        i2  = (t >= 2) ? (t - 2) % d : 0;
        b2  = (t >= 2) ? ((t - 2) / d) % 2 : 0;
        i3  = (t >= 3) ? (t - 3) % d : 0;
        b3  = (t >= 3) ? ((t - 3) / d) % 2 : 0;
        pt  = $sformatf("%s t=%0d", p, t);
        check({pt, " samp_we"},     we,    1);
        check({pt, " rec_clr"},     rec,   (idx == 0) ? 1 : 0);
        check({pt, " samp_waddr"},  waddr, idx * s + w);
        check({pt, " samp_lh"},     lh,    (d - 1 - idx) * s + (w + s - 1) % s);
        check({pt, " samp_fr"},     fr,    idx * s + (w + 1) % s);
        check({pt, " samp_br"},     br,    (d - 1 - idx) * s + (w + 1) % s);
        check({pt, " res_we"},      rwe,   (t >= 3) ? 1 : 0);
        check({pt, " res_waddr"},   rw,    i3 * 2 + b3);
        check({pt, " res_raddr_f"}, rf,    i2 * 2 + 1 - b2);
        check({pt, " res_raddr_b"}, rb,    (d - 1 - i2) * 2 + 1 - b2);
        check({pt, " out_valid"},   ov,    (t >= s * d + 3) ? 1 : 0);
    endtask

    task automatic check_reset(input string p);
        check({p, " a ds_tick"},   32'(a_tick),  0);
        check({p, " a samp_we"},   32'(a_we),    0);
        check({p, " a wdata"},     32'(a_wdata), 0);
        check({p, " a waddr"},     32'(a_waddr), 0);
        check({p, " a lh"},        32'(a_lh),    127);
        check({p, " a fr"},        32'(a_fr),    0);
        check({p, " a br"},        32'(a_br),    125);
        check({p, " a res_we"},    32'(a_rwe),   0);
        check({p, " a res_waddr"}, 32'(a_rw),    0);
        check({p, " a raddr_f"},   32'(a_rf),    0);
        check({p, " a raddr_b"},   32'(a_rb),    0);
        check({p, " a rec_clr"},   32'(a_rec),   0);
        check({p, " a out_valid"}, 32'(a_ov),    0);
        check({p, " b ds_tick"},   32'(b_tick),  0);
        check({p, " b wdata"},     32'(b_wdata), 0);
        check({p, " c lh"},        32'(c_lh),    39);
        check({p, " c br"},        32'(c_br),    36);
    endtask

    task automatic run_ticks(input int n);
        for (int e = 1; e <= n; e++) begin
            in_b = 2'((e - 1) % 4);
            @(posedge clk);
            #1;
            check($sformatf("a e=%0d ds_tick", e), 32'(a_tick), 1);
            check($sformatf("a e=%0d wdata", e), 32'(a_wdata), 5);
            check_tick("a", e - 1, 32, 4, 32'(a_we), 32'(a_rec), 32'(a_rwe), 32'(a_ov),
                       32'(a_waddr), 32'(a_lh), 32'(a_fr), 32'(a_br),
                       32'(a_rw), 32'(a_rf), 32'(a_rb));
            check($sformatf("c e=%0d ds_tick", e), 32'(c_tick), 1);
            check_tick("c", e - 1, 8, 5, 32'(c_we), 32'(c_rec), 32'(c_rwe), 32'(c_ov),
                       32'(c_waddr), 32'(c_lh), 32'(c_fr), 32'(c_br),
                       32'(c_rw), 32'(c_rf), 32'(c_rb));
            if (e - 1 == 48) begin
                check("c batch6 idx0 waddr", 32'(c_waddr), 1);
                check("c batch6 idx0 lh",    32'(c_lh),    35);
                check("c batch6 idx0 fr",    32'(c_fr),    2);
                check("c batch6 idx0 br",    32'(c_br),    37);
            end
            check($sformatf("b e=%0d ds_tick", e), 32'(b_tick), (e % 4 == 0) ? 1 : 0);
            if (e % 4 == 0) begin
                check($sformatf("b e=%0d wdata", e), 32'(b_wdata), 32'h1B);
                check_tick("b", e / 4 - 1, 32, 4, 32'(b_we), 32'(b_rec), 32'(b_rwe), 32'(b_ov),
                           32'(b_waddr), 32'(b_lh), 32'(b_fr), 32'(b_br),
                           32'(b_rw), 32'(b_rf), 32'(b_rb));
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b1;
        run_ticks(200);

        // Asynchronous reset mid-run: outputs must return to reset values without a clock edge.
        rst = 1'b0;
        #1;
        check_reset("mid0");
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_ticks(70);
        rst = 1'b0;
        #1;
        check_reset("tick70");
        repeat (2) @(posedge clk);
        #1;
        check_reset("tick70 held");
        rst = 1'b1;
        run_ticks(40);

`ifdef BATCH_IN_VALID_EN
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            int k;
            iv_a = (e % 2 == 1);
            @(posedge clk);
            #1;
            k = (e - 1) / 2;
            if (e % 2 == 1) begin
                check($sformatf("v e=%0d ds_tick", e), 32'(a_tick), 1);
                check_tick("v", k, 32, 4, 32'(a_we), 32'(a_rec), 32'(a_rwe), 32'(a_ov),
                           32'(a_waddr), 32'(a_lh), 32'(a_fr), 32'(a_br),
                           32'(a_rw), 32'(a_rf), 32'(a_rb));
            end else begin
                check($sformatf("v e=%0d idle ds_tick", e), 32'(a_tick), 0);
                check($sformatf("v e=%0d idle res_we", e), 32'(a_rwe), 0);
                check($sformatf("v e=%0d idle out_valid", e), 32'(a_ov), 0);
                check($sformatf("v e=%0d idle rec_clr", e), 32'(a_rec), 0);
                check($sformatf("v e=%0d idle waddr", e), 32'(a_waddr), k * 4);
            end
        end
        iv_a = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
